ysyx_23060025_ifu_queue_stage: RTL and testbench
================================================

// Module: ysyx_23060025_ifu_queue_stage
// PURPOSE
//  Next-generation fetch stage: decoupled fetch unit with a DEPTH-entry {inst,pc} queue between the icache and the IDU.
//  Keeps one icache request in flight while the queue has room, so fetch runs ahead of a stalled IDU.
//  Takes next-PC predictions from the BPU and IDU redirects; stale responses are dropped via an epoch bit.
// PARAMETERS
//  ADDR_WIDTH  32               PC / fetch address width
//  DATA_WIDTH  32               instruction width
//  DEPTH       4                queue entries; power of two, >=2
//  RESET_PC    `PC_RESET_VAL    first fetch address after reset
// PORTS
//  clock                 in   1        single clock, all state on posedge
//  reset                 in   1        synchronous, active-low (0 = reset)
//  ds_allowin_i          in   1        IDU accepts head entry this cycle
//  fs_to_ds_valid_o      out  1        head entry valid
//  if_to_id_bqu_bus_o    out  D+A      {inst, pc} of head entry
//  idu_valid_i           in   1        qualifies idu_flush_i
//  idu_flush_i           in   1        redirect request
//  idu_flush_pc_i        in   A        redirect target
//  ebreak_flag_i         in   1        stop issuing new fetches
//  bpu_pc_o              out  A        PC about to be issued (BPU lookup key)
//  bpu_pc_predict_i      in   A        predicted successor of bpu_pc_o (same cycle)
//  out_psel              out  1        icache request active
//  out_paddr             out  A        request address, registered
//  out_pready            in   1        one-cycle response strobe
//  out_prdata            in   D        instruction, valid with out_pready
// BEHAVIOUR
//  Reset (reset==0): out_psel=0, out_paddr=0, fs_to_ds_valid_o=0, bus=0, queue empty,
//   fetch_pc=RESET_PC, epoch=0, FSM=IDLE. Reset mid-request: pending response ignored (FSM IDLE).
//  flush = idu_flush_i & idu_valid_i; highest priority over all other events.
//  FSM: IDLE (no request), WAIT (out_psel=1), HALT (ebreak seen).
//   IDLE->WAIT when space & ~ebreak_flag_i: out_paddr<=fetch_pc, req_epoch<=epoch, fetch_pc<=bpu_pc_predict_i.
//   WAIT: out_psel and out_paddr held stable until out_pready.
//   WAIT & pready: push {out_prdata,out_paddr} iff req_epoch==epoch, else drop;
//    if space & ~ebreak & ~flush: issue next request back-to-back (stay WAIT, new paddr next cycle); else ->IDLE.
//   any state & ebreak_flag_i & ~flush: no new issue; IDLE->HALT, WAIT finishes its request then ->HALT.
//   HALT -> IDLE only on flush.
//  space = (count - pop + push_this_cycle) < DEPTH, computed before issue; never overflows.
//  flush: queue cleared next cycle, epoch toggles, fetch_pc<=idu_flush_pc_i;
//   fs_to_ds_valid_o forced 0 in the flush cycle; in-flight request completes and is dropped;
//   first redirected request issued no earlier than the cycle after flush (or after the stale pready).
//  Queue: circular, log2(DEPTH)-bit pointers wrap modulo DEPTH, count is log2(DEPTH)+1 bits.
//   pop = fs_to_ds_valid_o & ds_allowin_i; push and pop in same cycle at full or empty are legal.
//  pc+4 is never computed here: sequential successor comes from the BPU.
// CONFIGURATION
//  IFU_QUEUE_BYPASS_EN defined: queue empty & current-epoch pready -> entry driven on bus and
//   fs_to_ds_valid_o same cycle; if ds_allowin_i it is not written to the queue (0-cycle latency).
//  Not defined: every response is written first; earliest valid is the cycle after pready (1-cycle latency).
// STRUCTURE
//  Shared define file: FS_TO_DS_DATA_BUS width, PC_RESET_VAL, FSM state encodings (IDLE/WAIT/HALT).
//  One sub-module: ysyx_23060025_ifu_fifo (DEPTH x (D+A) storage, push/pop/clear, count, full/empty).
//  Top: FSM, fetch_pc, epoch, icache interface, bypass mux.
// TESTING
//  Reset released, icache 1-cycle, BPU=pc+4, ds_allowin_i=1 -> paddr 0x30000000,04,08...; bus pc in order.
//  ds_allowin_i=0, DEPTH=4 -> exactly 4 entries queued, out_psel 0 afterwards; release -> pops 4, resumes.
//  flush to 0x30000100 while WAIT on 0x30000010 (pready 3 cycles later) -> data for 0x10 dropped, next paddr 0x30000100.
//  flush same cycle as pop and push with queue full -> valid_o=0 that cycle, queue empty next cycle, no stale entry issued.
//  ebreak_flag_i during WAIT -> request completes, FSM HALT, no further psel until flush.
//  reset=0 for 1 cycle mid-WAIT -> psel 0 next cycle, late pready ignored, refetch from RESET_PC; bypass on/off latency 0/1.

Source files
------------

// File: rtl/ysyx_23060025_ifu_queue_stage_pkg.sv
// Shared constants for the decoupled fetch stage: reset PC, default bus widths
// and the fetch FSM state encoding.
package ysyx_23060025_ifu_queue_stage_pkg;

   localparam int          DEF_ADDR_WIDTH    = 32;
   localparam int          DEF_DATA_WIDTH    = 32;
   localparam int          FS_TO_DS_DATA_BUS = DEF_DATA_WIDTH + DEF_ADDR_WIDTH;
   localparam logic [31:0] PC_RESET_VAL      = 32'h3000_0000;

   typedef enum logic [1:0] {
      FS_IDLE = 2'd0,
      FS_WAIT = 2'd1,
      FS_HALT = 2'd2
   } fs_state_e;

endpackage

// File: rtl/ysyx_23060025_ifu_fifo.sv
// Circular {inst,pc} queue between the icache and the IDU.
// Clear has priority over push and pop; DEPTH must be a power of two.
module ysyx_23060025_ifu_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   input  logic             clear_i,
   output logic [WIDTH-1:0] head_data_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_data_o = mem_q[rd_ptr_q];
   assign count_o     = count_q;
   assign full_o      = (count_q == CW'(DEPTH));
   assign empty_o     = (count_q == '0);

endmodule

// File: rtl/ysyx_23060025_ifu_queue_stage.sv
// Decoupled fetch stage: one icache request in flight, epoch-tagged responses, DEPTH-entry queue to IDU.
// Optional IFU_QUEUE_BYPASS_EN lets a response reach the IDU in the same cycle when the queue is empty.
module ysyx_23060025_ifu_queue_stage
   import ysyx_23060025_ifu_queue_stage_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(PC_RESET_VAL)
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           ds_allowin_i,
   output logic                           fs_to_ds_valid_o,
   output logic [DATA_WIDTH+ADDR_WIDTH-1:0] if_to_id_bqu_bus_o,
   input  logic                           idu_valid_i,
   input  logic                           idu_flush_i,
   input  logic [ADDR_WIDTH-1:0]          idu_flush_pc_i,
   input  logic                           ebreak_flag_i,
   output logic [ADDR_WIDTH-1:0]          bpu_pc_o,
   input  logic [ADDR_WIDTH-1:0]          bpu_pc_predict_i,
   output logic                           out_psel,
   output logic [ADDR_WIDTH-1:0]          out_paddr,
   input  logic                           out_pready,
   input  logic [DATA_WIDTH-1:0]          out_prdata
);

   localparam int BW = DATA_WIDTH + ADDR_WIDTH;
   localparam int CW = $clog2(DEPTH) + 1;

   fs_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic                  epoch_q, epoch_d;
   logic                  req_epoch_q, req_epoch_d;

   logic          flush, resp_ok, space, issue;
   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [CW:0]   next_count;
   logic [BW-1:0] fifo_head, resp_entry;

   assign flush      = idu_flush_i & idu_valid_i;
   assign resp_ok    = (state_q == FS_WAIT) & out_pready & (req_epoch_q == epoch_q) & ~flush;
   assign resp_entry = {out_prdata, paddr_q};

`ifdef IFU_QUEUE_BYPASS_EN
   logic bypass;
   assign bypass             = fifo_empty & resp_ok;
   assign fs_to_ds_valid_o   = ~flush & (~fifo_empty | bypass);
   assign if_to_id_bqu_bus_o = ~fs_to_ds_valid_o ? '0 : (fifo_empty ? resp_entry : fifo_head);
   assign fifo_pop           = fs_to_ds_valid_o & ds_allowin_i & ~fifo_empty;
   assign fifo_push          = resp_ok & ~(bypass & ds_allowin_i) & (~fifo_full | fifo_pop);
`else
   assign fs_to_ds_valid_o   = ~fifo_empty & ~flush;
   assign if_to_id_bqu_bus_o = fs_to_ds_valid_o ? fifo_head : '0;
   assign fifo_pop           = fs_to_ds_valid_o & ds_allowin_i;
   assign fifo_push          = resp_ok & (~fifo_full | fifo_pop);
`endif

   // Occupancy after this cycle's push/pop decides whether another request can be launched.
   assign next_count = {1'b0, fifo_count} + {{CW{1'b0}}, fifo_push} - {{CW{1'b0}}, fifo_pop};
   assign space      = next_count < (CW+1)'(DEPTH);

   ysyx_23060025_ifu_fifo #(
      .WIDTH (BW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .push_i      (fifo_push),
      .push_data_i (resp_entry),
      .pop_i       (fifo_pop),
      .clear_i     (flush),
      .head_data_o (fifo_head),
      .count_o     (fifo_count),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      paddr_d     = paddr_q;
      epoch_d     = epoch_q;
      req_epoch_d = req_epoch_q;
      issue       = 1'b0;
      case (state_q)
         FS_IDLE: begin
            if (!flush) begin
               if (ebreak_flag_i) begin
                  state_d = FS_HALT;
               end else if (space) begin
                  issue   = 1'b1;
                  state_d = FS_WAIT;
               end
            end
         end
         FS_WAIT: begin
            if (out_pready) begin
               if (space && !ebreak_flag_i && !flush) begin
                  issue = 1'b1;
               end else if (ebreak_flag_i && !flush) begin
                  state_d = FS_HALT;
               end else begin
                  state_d = FS_IDLE;
               end
            end
         end
         FS_HALT: begin
            if (flush) begin
               state_d = FS_IDLE;
            end
         end
         default: state_d = FS_IDLE;
      endcase
      if (issue) begin
         paddr_d     = fetch_pc_q;
         req_epoch_d = epoch_q;
         fetch_pc_d  = bpu_pc_predict_i;
      end
      // Issue never coincides with a flush, so the redirect always wins the next PC.
      if (flush) begin
         epoch_d    = ~epoch_q;
         fetch_pc_d = idu_flush_pc_i;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= FS_IDLE;
         fetch_pc_q  <= RESET_PC;
         paddr_q     <= '0;
         epoch_q     <= 1'b0;
         req_epoch_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         paddr_q     <= paddr_d;
         epoch_q     <= epoch_d;
         req_epoch_q <= req_epoch_d;
      end
   end

   assign out_psel  = (state_q == FS_WAIT);
   assign out_paddr = paddr_q;
   assign bpu_pc_o  = fetch_pc_q;

endmodule

// File: tb/tb_ysyx_23060025_ifu_queue_stage.sv
// Directed bench for the decoupled fetch stage: icache responder, pc+4 BPU and a
// scoreboard of expected {inst,pc} entries checked whenever the IDU pops.
module tb_ysyx_23060025_ifu_queue_stage;

   localparam logic [31:0] RESET_PC = 32'h3000_0000;
   localparam logic [31:0] MAGIC    = 32'hDEAD_BEEF;

   logic        clock;
   logic        reset;
   logic        ds_allowin_i;
   logic        fs_to_ds_valid_o;
   logic [63:0] if_to_id_bqu_bus_o;
   logic        idu_valid_i;
   logic        idu_flush_i;
   logic [31:0] idu_flush_pc_i;
   logic        ebreak_flag_i;
   logic [31:0] bpu_pc_o;
   logic [31:0] bpu_pc_predict_i;
   logic        out_psel;
   logic [31:0] out_paddr;
   logic        out_pready;
   logic [31:0] out_prdata;

   int          total = 0;
   int          bad   = 0;
   logic [63:0] sb [$];
   logic        stale;
   logic        reqSeen;
   logic [31:0] expAddr;
   logic [31:0] curReqAddr;
   int          respLat;
   logic        respEn;
   logic        forcePready;
   int          waitCnt;

   ysyx_23060025_ifu_queue_stage dut (
      .clock              (clock),
      .reset              (reset),
      .ds_allowin_i       (ds_allowin_i),
      .fs_to_ds_valid_o   (fs_to_ds_valid_o),
      .if_to_id_bqu_bus_o (if_to_id_bqu_bus_o),
      .idu_valid_i        (idu_valid_i),
      .idu_flush_i        (idu_flush_i),
      .idu_flush_pc_i     (idu_flush_pc_i),
      .ebreak_flag_i      (ebreak_flag_i),
      .bpu_pc_o           (bpu_pc_o),
      .bpu_pc_predict_i   (bpu_pc_predict_i),
      .out_psel           (out_psel),
      .out_paddr          (out_paddr),
      .out_pready         (out_pready),
      .out_prdata         (out_prdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   assign bpu_pc_predict_i = bpu_pc_o + 32'd4;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rstN, input logic allow, input logic flush,
                                input logic [31:0] flushPc, input logic ebreak);
      @(posedge clock);
      #1;
      reset          = rstN;
      ds_allowin_i   = allow;
      idu_valid_i    = flush;
      idu_flush_i    = flush;
      idu_flush_pc_i = flushPc;
      ebreak_flag_i  = ebreak;
   endtask

   task automatic sampleCycle();
      @(negedge clock);
      #1;
   endtask

   task automatic waitNewReq(input logic [31:0] addr, output logic found);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         sampleCycle();
         if (out_psel && out_paddr == addr) found = 1'b1;
      end
   endtask

   // icache model: answers each request respLat cycles after it appears.
   always @(posedge clock) begin
      #2;
      if (respEn) begin
         out_pready = 1'b0;
         if (out_psel && reset) begin
            waitCnt++;
            if (waitCnt >= respLat) begin
               out_pready = 1'b1;
               out_prdata = out_paddr ^ MAGIC;
               waitCnt    = 0;
            end
         end else begin
            waitCnt = 0;
         end
      end else begin
         out_pready = forcePready;
         out_prdata = 32'hBAD0_0BAD;
      end
   end

   // Scoreboard: expected entries pushed on current-epoch responses, compared on every pop.
   always @(negedge clock) begin
      logic [63:0] e;
      if (!reset) begin
         sb.delete();
         stale   = 1'b0;
         reqSeen = 1'b0;
         expAddr = RESET_PC;
      end else begin
         if (out_psel && !reqSeen) begin
            checkOutput("paddr", {32'd0, out_paddr}, {32'd0, expAddr});
            curReqAddr = expAddr;
            expAddr    = expAddr + 32'd4;
            reqSeen    = 1'b1;
         end
         if (out_psel && out_pready) begin
            if (!stale && !(idu_flush_i && idu_valid_i)) sb.push_back({curReqAddr ^ MAGIC, curReqAddr});
            stale   = 1'b0;
            reqSeen = 1'b0;
         end
         if (fs_to_ds_valid_o && ds_allowin_i) begin
            if (sb.size() == 0) begin
               checkOutput("pop_unexpected", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               checkOutput("bus", if_to_id_bqu_bus_o, e);
            end
         end
         if (idu_flush_i && idu_valid_i) begin
            checkOutput("flush_valid", {63'd0, fs_to_ds_valid_o}, 64'd0);
            sb.delete();
            stale   = out_psel && !out_pready;
            expAddr = idu_flush_pc_i;
         end
      end
   end

   initial begin
      logic found;
      int   pselCycles;
      reset = 1'b0; ds_allowin_i = 1'b1; idu_valid_i = 1'b0; idu_flush_i = 1'b0;
      idu_flush_pc_i = '0; ebreak_flag_i = 1'b0;
      out_pready = 1'b0; out_prdata = '0;
      respEn = 1'b1; respLat = 1; forcePready = 1'b0; waitCnt = 0;

      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      sampleCycle();
      checkOutput("rst_psel",  {63'd0, out_psel}, 64'd0);
      checkOutput("rst_paddr", {32'd0, out_paddr}, 64'd0);
      checkOutput("rst_valid", {63'd0, fs_to_ds_valid_o}, 64'd0);
      checkOutput("rst_bus",   if_to_id_bqu_bus_o, 64'd0);

      // Streaming with a 1-cycle icache; first response shows the bypass latency.
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         sampleCycle();
         if (out_psel && out_pready) found = 1'b1;
      end
      checkOutput("first_resp", {63'd0, found}, 64'd1);
`ifdef IFU_QUEUE_BYPASS_EN
      checkOutput("lat_same", {63'd0, fs_to_ds_valid_o}, 64'd1);
`else
      checkOutput("lat_same", {63'd0, fs_to_ds_valid_o}, 64'd0);
      sampleCycle();
      checkOutput("lat_next", {63'd0, fs_to_ds_valid_o}, 64'd1);
`endif
      repeat (20) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);

      $display("[TB] backpressure: queue fills and fetch stops");
      repeat (20) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      sampleCycle();
      checkOutput("full_psel",  {63'd0, out_psel}, 64'd0);
      checkOutput("full_valid", {63'd0, fs_to_ds_valid_o}, 64'd1);
      checkOutput("full_count", 64'(sb.size()), 64'd4);
      repeat (20) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      sampleCycle();
      checkOutput("resume_psel", {63'd0, out_psel}, 64'd1);

      $display("[TB] flush during an in-flight request");
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      respLat = 5;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      waitNewReq(32'h3000_0010, found);
      checkOutput("req_0x10", {63'd0, found}, 64'd1);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h3000_0100, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      waitNewReq(32'h3000_0100, found);
      checkOutput("redirect_req", {63'd0, found}, 64'd1);

      $display("[TB] flush with a full queue and a pop in the same cycle");
      repeat (30) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      sampleCycle();
      checkOutput("full2_valid", {63'd0, fs_to_ds_valid_o}, 64'd1);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h3000_0200, 1'b0);
      sampleCycle();
      checkOutput("flushcyc_valid", {63'd0, fs_to_ds_valid_o}, 64'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      sampleCycle();
      checkOutput("postflush_empty", {63'd0, fs_to_ds_valid_o}, 64'd0);
      repeat (15) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);

      $display("[TB] ebreak halts fetch until a flush");
      respLat = 3;
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         sampleCycle();
         if (out_psel && !out_pready) found = 1'b1;
      end
      checkOutput("ebreak_req", {63'd0, found}, 64'd1);
      repeat (12) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
      pselCycles = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
         sampleCycle();
         if (out_psel) pselCycles++;
      end
      checkOutput("halt_psel", 64'(pselCycles), 64'd0);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h3000_0300, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      waitNewReq(32'h3000_0300, found);
      checkOutput("unhalt_req", {63'd0, found}, 64'd1);

      $display("[TB] reset pulse in the middle of a request");
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         sampleCycle();
         if (out_psel && !out_pready) found = 1'b1;
      end
      checkOutput("midreq", {63'd0, found}, 64'd1);
      respEn = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      forcePready = 1'b1;
      sampleCycle();
      checkOutput("rst_mid_psel", {63'd0, out_psel}, 64'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      forcePready = 1'b0;
      respEn      = 1'b1;
      respLat     = 1;
      waitNewReq(RESET_PC, found);
      checkOutput("refetch_reset_pc", {63'd0, found}, 64'd1);
      repeat (15) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      sampleCycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
